miss_req_tx: RTL and testbench



---
 rtl/miss_req_tx.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_miss_req_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_req_tx.sv
// miss_req_tx: MoldUDP64 retransmission request transmitter.
//
// Missing-sequence reports from the miss detector are queued in a small
// FIFO. Each report becomes one or more 20-byte request packets:
// 10-byte session, 8-byte sequence number and 2-byte message count, all
// big-endian. Each packet goes out as three beats on a 64-bit valid/ready
// bus, with the first wire byte on bits [7:0]. A gap larger than
// MAX_REQ_CNT is split across back-to-back requests.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   miss_seq_num_v_i      - report valid pulse (no backpressure)
//   miss_seq_num_sid_i    - session id of the gap
//   miss_seq_num_start_i  - first missing sequence number
//   miss_seq_num_cnt_i    - number of missing messages (0 = ignored)
//   req_valid_o/ready_i   - request beat handshake
//   req_data_o/keep_o     - beat payload and byte enables
//   req_start_o/last_o    - first / last beat of a packet
//   busy_o                - FIFO non-empty or packet generation in progress
//   drop_o                - one-cycle pulse: a report was lost (FIFO full)
//
// Build option: define MISS_REQ_MERGE_EN to merge a report that directly
// continues the newest queued gap of the same session into that entry.

module miss_req_tx #(
  parameter int              SEQ_NUM_W   = 18,
  parameter int              SID_W       = 80,
  parameter int              ML_W        = 16,
  parameter logic [ML_W-1:0] MAX_REQ_CNT = 16'hFFFF,
  parameter int              FIFO_D      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_seq_num_v_i,
  input  logic [SID_W-1:0]     miss_seq_num_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_seq_num_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [63:0]          req_data_o,
  output logic [7:0]           req_keep_o,
  output logic                 req_start_o,
  output logic                 req_last_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = (SEQ_NUM_W > ML_W) ? SEQ_NUM_W : ML_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } state_e;

  // Count carried by one request: the remaining gap, capped at MAX_REQ_CNT.
  function automatic logic [CMP_W-1:0] req_cnt(input logic [SEQ_NUM_W-1:0] rem);
    logic [CMP_W-1:0] r;
    logic [CMP_W-1:0] m;
    r = CMP_W'(rem);
    m = CMP_W'(MAX_REQ_CNT);
    req_cnt = (r > m) ? m : r;
  endfunction

  // Beat payload for a given beat state. The packet is first laid out in
  // wire order (byte i at bits [8i+7:8i]), then the beat's slice is taken.
  function automatic logic [63:0] beat_data(input state_e st,
                                            input logic [SID_W-1:0] sid,
                                            input logic [SEQ_NUM_W-1:0] seq,
                                            input logic [ML_W-1:0] rc);
    logic [159:0] pkt;
    logic [63:0]  seq64;
    logic [15:0]  rc16;
    seq64 = 64'(seq);
    rc16  = 16'(rc);
    pkt   = 160'd0;
    for (int i = 0; i < 10; i++) begin
      pkt[8*i +: 8] = sid[SID_W-1-8*i -: 8];
    end
    for (int i = 0; i < 8; i++) begin
      pkt[80+8*i +: 8] = seq64[63-8*i -: 8];
    end
    pkt[144 +: 8] = rc16[15:8];
    pkt[152 +: 8] = rc16[7:0];
    case (st)
      S_B0:    beat_data = pkt[63:0];
      S_B1:    beat_data = pkt[127:64];
      S_B2:    beat_data = {32'd0, pkt[159:128]};
      default: beat_data = 64'd0;
    endcase
  endfunction

  // Pending-gap FIFO
  logic [SID_W-1:0]     f_sid_q   [FIFO_D];
  logic [SID_W-1:0]     f_sid_d   [FIFO_D];
  logic [SEQ_NUM_W-1:0] f_start_q [FIFO_D];
  logic [SEQ_NUM_W-1:0] f_start_d [FIFO_D];
  logic [SEQ_NUM_W-1:0] f_cnt_q   [FIFO_D];
  logic [SEQ_NUM_W-1:0] f_cnt_d   [FIFO_D];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // FSM and working registers
  state_e               state_q, state_d;
  logic [SID_W-1:0]     w_sid_q, w_sid_d;
  logic [SEQ_NUM_W-1:0] w_start_q, w_start_d;
  logic [SEQ_NUM_W-1:0] w_rem_q, w_rem_d;

  // Registered outputs
  logic                 req_valid_q, req_valid_d;
  logic [63:0]          req_data_q, req_data_d;
  logic [7:0]           req_keep_q, req_keep_d;
  logic                 req_start_q, req_start_d;
  logic                 req_last_q, req_last_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic                 pop_s;
  logic                 rep_nz_s;
  logic                 merge_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 beat_acc_s;
  logic [SEQ_NUM_W-1:0] rc_seq_s;
  logic [SEQ_NUM_W-1:0] rem_after_s;

  assign fifo_empty_s = (count_q == CNT_W'(0));
  assign fifo_full_s  = (count_q == CNT_W'(FIFO_D));
  assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s;
  assign rep_nz_s     = miss_seq_num_v_i && (miss_seq_num_cnt_i != {SEQ_NUM_W{1'b0}});
  assign beat_acc_s   = req_valid_q && req_ready_i;
  assign rc_seq_s     = SEQ_NUM_W'(req_cnt(w_rem_q));
  assign rem_after_s  = w_rem_q - rc_seq_s;

`ifdef MISS_REQ_MERGE_EN
  logic [PTR_W-1:0]     newest_s;
  logic [SEQ_NUM_W:0]   merge_sum_s;
  logic                 newest_held_s;

  assign newest_s      = wr_ptr_q - PTR_W'(1);
  assign merge_sum_s   = {1'b0, f_cnt_q[newest_s]} + {1'b0, miss_seq_num_cnt_i};
  // The newest entry is only being popped when it is also the only entry.
  assign newest_held_s = !fifo_empty_s && !(pop_s && (count_q == CNT_W'(1)));
  assign merge_s       = rep_nz_s && newest_held_s
                       && (miss_seq_num_sid_i == f_sid_q[newest_s])
                       && (miss_seq_num_start_i == (f_start_q[newest_s] + f_cnt_q[newest_s]))
                       && !merge_sum_s[SEQ_NUM_W];
`else
  assign merge_s = 1'b0;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s = rep_nz_s && !merge_s && (!fifo_full_s || pop_s);
  assign drop_s = rep_nz_s && !merge_s && fifo_full_s && !pop_s;

  // FIFO next-state: storage writes, pointer and occupancy updates
  always_comb begin
    f_sid_d   = f_sid_q;
    f_start_d = f_start_q;
    f_cnt_d   = f_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_s) begin
      f_sid_d[wr_ptr_q]   = miss_seq_num_sid_i;
      f_start_d[wr_ptr_q] = miss_seq_num_start_i;
      f_cnt_d[wr_ptr_q]   = miss_seq_num_cnt_i;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
`ifdef MISS_REQ_MERGE_EN
    if (merge_s) begin
      f_cnt_d[newest_s] = merge_sum_s[SEQ_NUM_W-1:0];
    end else begin
      f_cnt_d[newest_s] = f_cnt_d[newest_s];
    end
`endif
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_D; i++) begin
        f_sid_q[i]   <= {SID_W{1'b0}};
        f_start_q[i] <= {SEQ_NUM_W{1'b0}};
        f_cnt_q[i]   <= {SEQ_NUM_W{1'b0}};
      end
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      f_sid_q   <= f_sid_d;
      f_start_q <= f_start_d;
      f_cnt_q   <= f_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: beats advance only on an accepted handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) state_d = S_B0;
        else               state_d = S_IDLE;
      end
      S_B0: begin
        if (beat_acc_s) state_d = S_B1;
        else            state_d = S_B0;
      end
      S_B1: begin
        if (beat_acc_s) state_d = S_B2;
        else            state_d = S_B1;
      end
      S_B2: begin
        if (beat_acc_s) begin
          // Leftover gap continues straight into the next request.
          if (rem_after_s != {SEQ_NUM_W{1'b0}}) state_d = S_B0;
          else                                  state_d = S_IDLE;
        end else begin
          state_d = S_B2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers: load on pop, advance after each completed request
  always_comb begin
    w_sid_d   = w_sid_q;
    w_start_d = w_start_q;
    w_rem_d   = w_rem_q;
    if (pop_s) begin
      w_sid_d   = f_sid_q[rd_ptr_q];
      w_start_d = f_start_q[rd_ptr_q];
      w_rem_d   = f_cnt_q[rd_ptr_q];
    end else if ((state_q == S_B2) && beat_acc_s) begin
      w_start_d = w_start_q + rc_seq_s;
      w_rem_d   = rem_after_s;
    end else begin
      w_sid_d   = w_sid_q;
    end
  end

  // Working register flops
  always_ff @(posedge clk) begin
    if (reset) begin
      w_sid_q   <= {SID_W{1'b0}};
      w_start_q <= {SEQ_NUM_W{1'b0}};
      w_rem_q   <= {SEQ_NUM_W{1'b0}};
    end else begin
      w_sid_q   <= w_sid_d;
      w_start_q <= w_start_d;
      w_rem_q   <= w_rem_d;
    end
  end

  // FSM outputs, derived from the next state so the port flops line up
  // with the state they describe; a stall keeps every input unchanged.
  always_comb begin
    req_valid_d = (state_d != S_IDLE);
    req_start_d = (state_d == S_B0);
    req_last_d  = (state_d == S_B2);
    req_data_d  = beat_data(state_d, w_sid_d, w_start_d, ML_W'(req_cnt(w_rem_d)));
    case (state_d)
      S_B0:    req_keep_d = 8'hFF;
      S_B1:    req_keep_d = 8'hFF;
      S_B2:    req_keep_d = 8'h0F;
      default: req_keep_d = 8'h00;
    endcase
    busy_d = (count_d != CNT_W'(0)) || (state_d != S_IDLE);
    drop_d = drop_s;
  end

  // Output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_data_q  <= 64'd0;
      req_keep_q  <= 8'd0;
      req_start_q <= 1'b0;
      req_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      req_keep_q  <= req_keep_d;
      req_start_q <= req_start_d;
      req_last_q  <= req_last_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_data_o  = req_data_q;
  assign req_keep_o  = req_keep_q;
  assign req_start_o = req_start_q;
  assign req_last_o  = req_last_q;
  assign busy_o      = busy_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_miss_req_tx.sv
// Testbench for miss_req_tx: a cycle table for reset/latency/zero-count,
// then directed sequences for split, wrap, backpressure, overflow, reset
// mid-packet and (build dependent) report merging.

module tb_miss_req_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_v;
  logic [79:0] miss_sid;
  logic [17:0] miss_start;
  logic [17:0] miss_cnt;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_data;
  logic [7:0]  req_keep;
  logic        req_start;
  logic        req_last;
  logic        busy;
  logic        drop;

  int checks = 0;
  int errors = 0;

  miss_req_tx dut (
    .clk                  (clk),
    .reset                (reset),
    .miss_seq_num_v_i     (miss_v),
    .miss_seq_num_sid_i   (miss_sid),
    .miss_seq_num_start_i (miss_start),
    .miss_seq_num_cnt_i   (miss_cnt),
    .req_valid_o          (req_valid),
    .req_ready_i          (req_ready),
    .req_data_o           (req_data),
    .req_keep_o           (req_keep),
    .req_start_o          (req_start),
    .req_last_o           (req_last),
    .busy_o               (busy),
    .drop_o               (drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        v;
    logic [79:0] sid;
    logic [17:0] st;
    logic [17:0] cn;
    logic        rdy;
    logic        e_valid;
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    logic        e_start;
    logic        e_last;
    logic        e_busy;
    logic        e_drop;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [79:0] sid,
                              input logic [17:0] st, input logic [17:0] cn,
                              input logic ev, input logic [63:0] ed,
                              input logic [7:0] ek, input logic es,
                              input logic el, input logic eb);
    vec_t r;
    r.rst = 1'b0; r.v = v; r.sid = sid; r.st = st; r.cn = cn; r.rdy = 1'b1;
    r.e_valid = ev; r.e_data = ed; r.e_keep = ek; r.e_start = es;
    r.e_last = el; r.e_busy = eb; r.e_drop = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  // Reference beat: build the 20 wire bytes, then slice beat k.
  function automatic logic [63:0] mdl_data(input int k, input logic [79:0] sid,
                                           input logic [63:0] seq, input logic [15:0] cnt);
    logic [7:0]  b [20];
    logic [63:0] d;
    for (int i = 0; i < 10; i++) b[i] = sid[8*(9-i) +: 8];
    for (int i = 0; i < 8; i++)  b[10+i] = seq[8*(7-i) +: 8];
    b[18] = cnt[15:8];
    b[19] = cnt[7:0];
    d = 64'd0;
    for (int j = 0; j < 8; j++) begin
      if (8*k + j < 20) d[8*j +: 8] = b[8*k + j];
    end
    return d;
  endfunction

  task automatic send(input logic [79:0] sid, input logic [17:0] st, input logic [17:0] cn);
    @(negedge clk);
    miss_v = 1'b1; miss_sid = sid; miss_start = st; miss_cnt = cn;
    @(negedge clk);
    miss_v = 1'b0;
  endtask

  // Collect one 3-beat packet. Every valid cycle is compared with the
  // expected beat, so a stalled beat must stay unchanged.
  task automatic expect_pkt(input string nm, input logic [79:0] sid, input logic [63:0] seq,
                            input logic [15:0] cnt, input int max_idle, input bit toggle,
                            output int idle_cycles);
    int  k = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    bit  rdy;
    idle_cycles = 0;
    while (k < 3) begin
      @(negedge clk);
      cyc++;
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      req_ready = rdy;
      if (!req_valid) begin
        if (started) begin
          chk($sformatf("%s bubble at beat %0d", nm, k), 64'(req_valid), 64'd1);
          return;
        end
        idle_cycles++;
        if (idle_cycles > max_idle) begin
          chk($sformatf("%s wait for B0", nm), 64'(idle_cycles), 64'(max_idle));
          return;
        end
      end else begin
        started = 1'b1;
        chk($sformatf("%s b%0d data", nm, k), req_data, mdl_data(k, sid, seq, cnt));
        chk($sformatf("%s b%0d keep", nm, k), 64'(req_keep), (k == 2) ? 64'h0F : 64'hFF);
        chk($sformatf("%s b%0d start", nm, k), 64'(req_start), 64'(k == 0));
        chk($sformatf("%s b%0d last", nm, k), 64'(req_last), 64'(k == 2));
        if (rdy) k++;
      end
    end
  endtask

  localparam logic [79:0] SID_A = 80'h0102_0304_0506_0708_090A;
  localparam logic [79:0] SID_B = 80'hA1B2_C3D4_E5F6_0718_293A;

  vec_t vecs [8];
  int   idl;

  initial begin
    reset = 1'b1; miss_v = 1'b0; miss_sid = 80'd0; miss_start = 18'd0;
    miss_cnt = 18'd0; req_ready = 1'b1;

    // Single gap sid 5 / start 100 / cnt 3 with ready high, then a cnt=0 report.
    vecs[0] = mk(1'b1, 80'd5, 18'd100, 18'd3, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b1, 64'h0, 8'hFF, 1'b1, 1'b0, 1'b1);
    vecs[3] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b1, 64'h0000_0000_0000_0500, 8'hFF, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b1, 64'h0000_0000_0300_6400, 8'h0F, 1'b0, 1'b1, 1'b1);
    vecs[5] = mk(1'b1, 80'd7, 18'd9,   18'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[6] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 80'd0, 18'd0,   18'd0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; miss_v = vecs[i].v; miss_sid = vecs[i].sid;
      miss_start = vecs[i].st; miss_cnt = vecs[i].cn; req_ready = vecs[i].rdy;
      chk($sformatf("v%0d valid", i), 64'(req_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d data", i), req_data, vecs[i].e_data);
      chk($sformatf("v%0d keep", i), 64'(req_keep), 64'(vecs[i].e_keep));
      chk($sformatf("v%0d start", i), 64'(req_start), 64'(vecs[i].e_start));
      chk($sformatf("v%0d last", i), 64'(req_last), 64'(vecs[i].e_last));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d drop", i), 64'(drop), 64'(vecs[i].e_drop));
    end
    miss_v = 1'b0;

    // Split 70000 into 65535 + 4465, no bubble between the two packets.
    send(SID_A, 18'd10, 18'd70000);
    expect_pkt("split0", SID_A, 64'd10, 16'd65535, 4, 1'b0, idl);
    expect_pkt("split1", SID_A, 64'd65545, 16'd4465, 0, 1'b0, idl);
    @(negedge clk);
    chk("split idle valid", 64'(req_valid), 64'd0);
    chk("split idle busy", 64'(busy), 64'd0);

    // Sequence wraps modulo 2^18 inside a split gap.
    send(SID_B, 18'd262143, 18'd65537);
    expect_pkt("wrap0", SID_B, 64'd262143, 16'd65535, 4, 1'b0, idl);
    expect_pkt("wrap1", SID_B, 64'd65534, 16'd2, 0, 1'b0, idl);

    // Backpressure: ready toggles, stalled beats must hold, exactly 3 beats.
    send(SID_A, 18'd777, 18'd9);
    expect_pkt("bp", SID_A, 64'd777, 16'd9, 6, 1'b1, idl);
    @(negedge clk);
    req_ready = 1'b1;
    chk("bp no extra beat", 64'(req_valid), 64'd0);

    // Overflow: FSM parked on a blocker packet, 6 reports into depth 4.
    req_ready = 1'b0;
    send(80'd99, 18'd1000, 18'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("ovf blocker valid", 64'(req_valid), 64'd1);
      chk($sformatf("ovf drop c%0d", i), 64'(drop), 64'(i == 5));
      miss_v = 1'b1; miss_sid = 80'(i + 16); miss_start = 18'(2000 + 10*i); miss_cnt = 18'(i + 1);
    end
    @(negedge clk);
    miss_v = 1'b0;
    chk("ovf drop second", 64'(drop), 64'd1);
    @(negedge clk);
    chk("ovf drop end", 64'(drop), 64'd0);
    chk("ovf busy", 64'(busy), 64'd1);
    expect_pkt("ovf blk", 80'd99, 64'd1000, 16'd1, 0, 1'b0, idl);
    for (int i = 0; i < 4; i++) begin
      expect_pkt($sformatf("ovf q%0d", i), 80'(i + 16), 64'(2000 + 10*i), 16'(i + 1), 3, 1'b0, idl);
      chk($sformatf("ovf q%0d gap", i), 64'(idl), 64'd1);
    end
    @(negedge clk);
    chk("ovf done valid", 64'(req_valid), 64'd0);
    chk("ovf done busy", 64'(busy), 64'd0);

    // Reset during B1 with another report queued.
    req_ready = 1'b0;
    send(SID_B, 18'd50, 18'd2);
    @(negedge clk);
    chk("rst B0 valid", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("rst B1 data", req_data, mdl_data(1, SID_B, 64'd50, 16'd2));
    miss_v = 1'b1; miss_sid = SID_A; miss_start = 18'd5; miss_cnt = 18'd1;
    @(negedge clk);
    miss_v = 1'b0;
    chk("rst pre busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_ready = 1'b1;
    chk("rst valid", 64'(req_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst quiet %0d", i), 64'({req_valid, busy}), 64'd0);
    end

    // Contiguous reports of one session behind a parked blocker.
    req_ready = 1'b0;
    send(80'd42, 18'd500, 18'd1);
    @(negedge clk);
    miss_v = 1'b1; miss_sid = 80'd1; miss_start = 18'd20; miss_cnt = 18'd5;
    @(negedge clk);
    miss_start = 18'd25; miss_cnt = 18'd7;
    @(negedge clk);
    miss_v = 1'b0;
    expect_pkt("mrg blk", 80'd42, 64'd500, 16'd1, 2, 1'b0, idl);
`ifdef MISS_REQ_MERGE_EN
    expect_pkt("mrg one", 80'd1, 64'd20, 16'd12, 3, 1'b0, idl);
`else
    expect_pkt("mrg a", 80'd1, 64'd20, 16'd5, 3, 1'b0, idl);
    expect_pkt("mrg b", 80'd1, 64'd25, 16'd7, 3, 1'b0, idl);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("mrg done", 64'({req_valid, busy}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
